// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory port arbiter.
// The size codes match the EX_MEM MemRead/MemWrite encoding.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_B    = 2'b01;
  localparam logic [1:0] SZ_H    = 2'b10;
  localparam logic [1:0] SZ_W    = 2'b11;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  // A store takes precedence when a read and a write are both requested.
  function automatic logic [1:0] dm_size(input logic [1:0] rd, input logic [1:0] wr);
    return (wr != SZ_NONE) ? wr : rd;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat.sv
// Memory latency counter: load starts the count at 1, and done flags the
// cycle in which the memory response is due.
module mem_lat_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic count_i,
  output logic done_o
);

  logic [2:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == 3'(MEM_LAT));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 3'd1;
    end else if (count_i && !done_o) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between the IF and MEM stages.
// Each access takes the sequence IDLE (grant), WAIT (MEM_LAT cycles), RESP (ready pulse).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_DM_RUN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic [1:0]        dm_read,
  input  logic [1:0]        dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_stall
);

  localparam int RUN_W = $clog2(MAX_DM_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic [RUN_W-1:0]  dm_run_q, dm_run_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic dm_req;
  logic if_win;
  logic lat_load;
  logic lat_count;
  logic lat_done;

  assign dm_req = (|dm_read) | (|dm_write);
  // Data normally wins; a waiting fetch gets the port once data has had MAX_DM_RUN grants in a row.
  assign if_win = if_req && (!dm_req || (dm_run_q == RUN_MAX));

  mem_lat_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_lat (
    .clk    (clk),
    .rst    (rst),
    .load_i (lat_load),
    .count_i(lat_count),
    .done_o (lat_done)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    dm_run_d    = dm_run_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    lat_load    = 1'b0;
    lat_count   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (if_win) begin
          grant_d    = GRANT_IF;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_size_d = SZ_W;
          mem_addr_d = if_addr;
          dm_run_d   = '0;
          lat_load   = 1'b1;
          state_d    = ST_WAIT;
        end else if (dm_req) begin
          grant_d     = GRANT_DM;
          mem_en_d    = 1'b1;
          mem_we_d    = |dm_write;
          mem_size_d  = dm_size(dm_read, dm_write);
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          lat_load    = 1'b1;
          state_d     = ST_WAIT;
          if (!if_req) begin
            dm_run_d = '0;
          end else if (dm_run_q != RUN_MAX) begin
            dm_run_d = dm_run_q + RUN_W'(1);
          end
        end
      end
      ST_WAIT: begin
        lat_count = 1'b1;
        if (lat_done) begin
          state_d = ST_RESP;
          if (grant_q == GRANT_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset discards any in-flight access, so no ready pulse can follow its release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= GRANT_IF;
      dm_run_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= SZ_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      dm_run_q    <= dm_run_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign pipe_stall = rst & ((if_req & ~if_ready_q) | (dm_req & ~dm_ready_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-2 memory model that
// remembers the most recent store and otherwise returns 0x20420000 + address.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic [1:0]  dm_read;
  logic [1:0]  dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        pipe_stall;

  int compared;
  int failCount;

  logic        lastWrValid;
  logic [31:0] lastWrAddr;
  logic [31:0] lastWrData;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_LAT   (2),
    .MAX_DM_RUN(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pipe_stall(pipe_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memLookup(input logic [31:0] a);
    if (lastWrValid && (lastWrAddr == a)) return lastWrData;
    return 32'h2042_0000 + a;
  endfunction

  // Memory model: read data appears after the issue cycle and is held until the next issue.
  initial begin
    lastWrValid = 1'b0;
    lastWrAddr  = '0;
    lastWrData  = '0;
    mem_rdata   = '0;
  end
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) begin
        lastWrValid <= 1'b1;
        lastWrAddr  <= mem_addr;
        lastWrData  <= mem_wdata;
      end else begin
        mem_rdata <= memLookup(mem_addr);
      end
    end
  end

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic [1:0] dmRead, input logic [1:0] dmWrite,
                               input logic [31:0] dmAddr, input logic [31:0] dmWdata);
    if_req   = ifReq;
    if_addr  = ifAddr;
    dm_read  = dmRead;
    dm_write = dmWrite;
    dm_addr  = dmAddr;
    dm_wdata = dmWdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitIssue(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    compared++;
    assert (ok) else begin
      failCount++;
      $error("[TB] FAIL %s: mem_en observed 0 within budget expected 1", tag);
    end
  endtask

  task automatic waitReady(input string tag, input bit isDm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if ((isDm ? dm_ready : if_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    compared++;
    assert (ok) else begin
      failCount++;
      $error("[TB] FAIL %s: ready observed 0 within budget expected 1", tag);
    end
  endtask

  initial begin
    logic [31:0] starveOrder [6];
    int          pulses;

    compared  = 0;
    failCount = 0;
    starveOrder = '{32'h200, 32'h200, 32'h100, 32'h200, 32'h200, 32'h100};

    // Reset state, with a fetch already pending so the forced-low stall is visible.
    rst = 1'b0;
    applyStimulus(1'b1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_en", {31'b0, mem_en}, 32'h0);
    checkOutput("rst_if_ready", {31'b0, if_ready}, 32'h0);
    checkOutput("rst_dm_ready", {31'b0, dm_ready}, 32'h0);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_stall", {31'b0, pipe_stall}, 32'h0);

    // Single fetch from 0x0 with exact cycle timing.
    rst = 1'b1;
    #1;
    checkOutput("t1_stall_pend", {31'b0, pipe_stall}, 32'h1);
    @(negedge clk);
    checkOutput("t1_issue_en", {31'b0, mem_en}, 32'h1);
    checkOutput("t1_issue_size", {30'b0, mem_size}, 32'h3);
    checkOutput("t1_issue_we", {31'b0, mem_we}, 32'h0);
    checkOutput("t1_issue_addr", mem_addr, 32'h0);
    @(negedge clk);
    checkOutput("t1_wait_en", {31'b0, mem_en}, 32'h0);
    checkOutput("t1_wait_rdy", {31'b0, if_ready}, 32'h0);
    checkOutput("t1_wait_stall", {31'b0, pipe_stall}, 32'h1);
    @(negedge clk);
    checkOutput("t1_resp_rdy", {31'b0, if_ready}, 32'h1);
    checkOutput("t1_resp_data", if_rdata, 32'h2042_0000);
    checkOutput("t1_resp_stall", {31'b0, pipe_stall}, 32'h0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("t1_after_rdy", {31'b0, if_ready}, 32'h0);
    checkOutput("t1_after_en", {31'b0, mem_en}, 32'h0);

    // Simultaneous fetch and word load: data first, then the fetch.
    applyStimulus(1'b1, 32'h40, 2'b11, 2'b00, 32'h3, 32'h0);
    waitIssue("t2_dm_issue");
    checkOutput("t2_dm_addr", mem_addr, 32'h3);
    checkOutput("t2_dm_we", {31'b0, mem_we}, 32'h0);
    waitReady("t2_dm_ready", 1'b1);
    checkOutput("t2_dm_rdata", dm_rdata, 32'h2042_0003);
    checkOutput("t2_if_not_rdy", {31'b0, if_ready}, 32'h0);
    checkOutput("t2_stall_if", {31'b0, pipe_stall}, 32'h1);
    applyStimulus(1'b1, 32'h40, 2'b00, 2'b00, 32'h3, 32'h0);
    @(negedge clk);
    checkOutput("t2_gap_en", {31'b0, mem_en}, 32'h0);
    waitIssue("t2_if_issue");
    checkOutput("t2_if_addr", mem_addr, 32'h40);
    checkOutput("t2_if_size", {30'b0, mem_size}, 32'h3);
    waitReady("t2_if_ready", 1'b0);
    checkOutput("t2_if_rdata", if_rdata, 32'h2042_0040);
    checkOutput("t2_dm_kept", dm_rdata, 32'h2042_0003);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);

    // Halfword store then halfword load from the same unaligned address.
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b10, 32'h3, 32'h5);
    waitIssue("t3_sh_issue");
    checkOutput("t3_sh_we", {31'b0, mem_we}, 32'h1);
    checkOutput("t3_sh_size", {30'b0, mem_size}, 32'h2);
    checkOutput("t3_sh_wdata", mem_wdata, 32'h5);
    checkOutput("t3_sh_addr", mem_addr, 32'h3);
    waitReady("t3_sh_ready", 1'b1);
    checkOutput("t3_sh_rdata_kept", dm_rdata, 32'h2042_0003);
    applyStimulus(1'b0, 32'h0, 2'b10, 2'b00, 32'h3, 32'h0);
    @(negedge clk);
    waitIssue("t3_lh_issue");
    checkOutput("t3_lh_we", {31'b0, mem_we}, 32'h0);
    checkOutput("t3_lh_size", {30'b0, mem_size}, 32'h2);
    waitReady("t3_lh_ready", 1'b1);
    checkOutput("t3_lh_rdata", dm_rdata, 32'h5);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);

    // Starvation guard: continuous data traffic with a fetch waiting.
    applyStimulus(1'b1, 32'h100, 2'b11, 2'b00, 32'h200, 32'h0);
    for (int k = 0; k < 6; k++) begin
      waitIssue($sformatf("t4_issue%0d", k));
      checkOutput($sformatf("t4_order%0d", k), mem_addr, starveOrder[k]);
      @(negedge clk);
    end
    waitReady("t4_if_ready", 1'b0);
    checkOutput("t4_if_rdata", if_rdata, 32'h2042_0100);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);

    // Asynchronous reset in the middle of a WAIT.
    applyStimulus(1'b0, 32'h0, 2'b11, 2'b00, 32'h8, 32'h0);
    @(negedge clk);
    waitIssue("t5_issue");
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("t5_mem_en", {31'b0, mem_en}, 32'h0);
    checkOutput("t5_mem_we", {31'b0, mem_we}, 32'h0);
    checkOutput("t5_mem_size", {30'b0, mem_size}, 32'h0);
    checkOutput("t5_mem_addr", mem_addr, 32'h0);
    checkOutput("t5_mem_wdata", mem_wdata, 32'h0);
    checkOutput("t5_if_rdata", if_rdata, 32'h0);
    checkOutput("t5_dm_rdata", dm_rdata, 32'h0);
    checkOutput("t5_stall", {31'b0, pipe_stall}, 32'h0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((mem_en !== 1'b0) || (if_ready !== 1'b0) || (dm_ready !== 1'b0)) pulses++;
    end
    checkOutput("t5_quiet_after", pulses, 32'h0);

    // Read and write together: handled as one word store.
    applyStimulus(1'b0, 32'h0, 2'b11, 2'b11, 32'h10, 32'hCAFE_F00D);
    waitIssue("t6_issue");
    checkOutput("t6_we", {31'b0, mem_we}, 32'h1);
    checkOutput("t6_size", {30'b0, mem_size}, 32'h3);
    checkOutput("t6_wdata", mem_wdata, 32'hCAFE_F00D);
    checkOutput("t6_addr", mem_addr, 32'h10);
    @(negedge clk);
    checkOutput("t6_single_en", {31'b0, mem_en}, 32'h0);
    waitReady("t6_ready", 1'b1);
    checkOutput("t6_rdata_kept", dm_rdata, 32'h0);
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failCount);
    $finish;
  end

endmodule
